// File: rtl/data_sram_responder_pkg.sv
// -----------------------------------------------------------------------------
// data_sram_responder_pkg
//
// Purpose: shared definitions for the data-memory responder.
//   - Byte offsets of the memory-mapped register window.
//   - reg_id_e: one-hot-free identifier of the addressed register.
//   - decode_reg(): maps a window offset onto reg_id_e.
//   - byte_merge(): applies a 4-bit byte-write-enable mask to a 32-bit word.
//
// Ports: none (package).
// -----------------------------------------------------------------------------
package data_sram_responder_pkg;

    // Register window offsets (addr[15:0] within the MMIO page).
    localparam logic [15:0] OFF_LED     = 16'h0000;
    localparam logic [15:0] OFF_NUM     = 16'h0004;
    localparam logic [15:0] OFF_SWITCH  = 16'h0008;
    localparam logic [15:0] OFF_TIMER   = 16'h000C;
    localparam logic [15:0] OFF_SCRATCH = 16'h0010;

    typedef enum logic [2:0] {
        REG_NONE    = 3'd0,
        REG_LED     = 3'd1,
        REG_NUM     = 3'd2,
        REG_SWITCH  = 3'd3,
        REG_TIMER   = 3'd4,
        REG_SCRATCH = 3'd5
    } reg_id_e;

    // Exact-offset decode: anything not listed reads 0 and ignores writes.
    function automatic reg_id_e decode_reg(input logic [15:0] offset);
        reg_id_e id;
        case (offset)
            OFF_LED:     id = REG_LED;
            OFF_NUM:     id = REG_NUM;
            OFF_SWITCH:  id = REG_SWITCH;
            OFF_TIMER:   id = REG_TIMER;
            OFF_SCRATCH: id = REG_SCRATCH;
            default:     id = REG_NONE;
        endcase
        return id;
    endfunction

    // Lane i of the result comes from wdata when wen[i] is set, else from old.
    function automatic logic [31:0] byte_merge(input logic [31:0] old,
                                               input logic [31:0] wdata,
                                               input logic [3:0]  wen);
        logic [31:0] merged;
        merged = old;
        for (int i = 0; i < 4; i++) begin
            if (wen[i]) begin
                merged[8*i +: 8] = wdata[8*i +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/data_sram_responder_sram_byte_ram.sv
// -----------------------------------------------------------------------------
// sram_byte_ram
//
// Purpose: single-port 2^AW x 32 data RAM with per-byte write enables and a
// registered read port (one-cycle latency). Each byte lane is its own array so
// every lane maps onto a plain inferred block RAM with a simple write enable.
// The read register only loads on a read strobe, so it holds its value across
// writes and idle cycles. The array contents are never reset; only the read
// register is.
//
// Ports:
//   clk     in   clock
//   resetn  in   synchronous active-low reset of the read register
//   we      in   [3:0] byte write enables (caller gates these with reset)
//   re      in   read strobe
//   addr    in   [AW-1:0] word address
//   wdata   in   [31:0] write data, lane i = bits [8i+7:8i]
//   rdata   out  [31:0] registered read data
// -----------------------------------------------------------------------------
module sram_byte_ram #(
    parameter int AW = 14
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic [3:0]    we,
    input  logic          re,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    localparam int DEPTH = 1 << AW;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] lane_mem [DEPTH];
            logic [7:0] lane_rdata_reg;

            always_ff @(posedge clk) begin
                if (we[gi]) begin
                    lane_mem[addr] <= wdata[8*gi +: 8];
                end
            end

            always_ff @(posedge clk) begin
                if (!resetn) begin
                    lane_rdata_reg <= 8'h00;
                end else if (re) begin
                    lane_rdata_reg <= lane_mem[addr];
                end
            end

            assign rdata[8*gi +: 8] = lane_rdata_reg;
        end
    endgenerate

endmodule

// File: rtl/data_sram_responder.sv
// -----------------------------------------------------------------------------
// data_sram_responder
//
// Purpose: responder end of the core's data-SRAM port. Requests (en / wen /
// addr / wdata) are accepted every cycle; reads return data one cycle later on
// rdata. Addresses whose upper half equals MMIO_HI hit a small register window
// (LED, NUM, SWITCH, TIMER, SCRATCH); everything else goes to a word-addressed
// RAM that aliases above RAM_AW+2 address bits.
//
// Ports:
//   clk              in   clock
//   resetn           in   synchronous active-low reset
//   data_sram_en     in   request valid
//   data_sram_wen    in   [3:0] byte write enables (0 = read)
//   data_sram_addr   in   [31:0] byte address, [1:0] ignored
//   data_sram_wdata  in   [31:0] write data
//   data_sram_rdata  out  [31:0] registered read data
//   switch           in   [7:0] external switch levels
//   led              out  [15:0] LED register
//   num              out  [31:0] numeric-display register
// -----------------------------------------------------------------------------
module data_sram_responder
    import data_sram_responder_pkg::*;
#(
    parameter int          RAM_AW  = 14,
    parameter logic [15:0] MMIO_HI = 16'hBFAF
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        data_sram_en,
    input  logic [3:0]  data_sram_wen,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,
    input  logic [7:0]  switch,
    output logic [15:0] led,
    output logic [31:0] num
);

    // ---------------------------------------------------------------- decode
    logic    mmio_sel;
    logic    rd_req;
    logic    wr_req;
    reg_id_e reg_id;

    assign mmio_sel = (data_sram_addr[31:16] == MMIO_HI);
    assign rd_req   = data_sram_en && (data_sram_wen == 4'b0000);
    assign wr_req   = data_sram_en && (data_sram_wen != 4'b0000);
    assign reg_id   = decode_reg(data_sram_addr[15:0]);

    // ------------------------------------------------------------------- RAM
    // Requests presented while reset is asserted are discarded, so the RAM
    // strobes are qualified with resetn here.
    logic [3:0]  ram_we;
    logic        ram_re;
    logic [31:0] ram_rdata;

    assign ram_we = (resetn && wr_req && !mmio_sel) ? data_sram_wen : 4'b0000;
    assign ram_re = resetn && rd_req && !mmio_sel;

    sram_byte_ram #(
        .AW (RAM_AW)
    ) u_ram (
        .clk    (clk),
        .resetn (resetn),
        .we     (ram_we),
        .re     (ram_re),
        .addr   (data_sram_addr[RAM_AW+1:2]),
        .wdata  (data_sram_wdata),
        .rdata  (ram_rdata)
    );

    // -------------------------------------------------------- register window
    logic [15:0] led_reg,         led_next;
    logic [31:0] num_reg,         num_next;
    logic [31:0] timer_reg,       timer_next;
    logic [31:0] scratch_reg,     scratch_next;
    logic [31:0] mmio_rdata_reg,  mmio_rdata_next;
    logic        sel_mmio_reg,    sel_mmio_next;
    logic [31:0] mmio_read_value;
    logic        mmio_wr;

    assign mmio_wr = wr_req && mmio_sel;

    // Combinational read value of the addressed register as of this cycle.
    // TIMER returns the live count, so rdata lags the counter by one.
    always_comb begin
        mmio_read_value = 32'h0000_0000;
        case (reg_id)
            REG_LED:     mmio_read_value = {16'h0000, led_reg};
            REG_NUM:     mmio_read_value = num_reg;
            REG_SWITCH:  mmio_read_value = {24'h00_0000, switch};
            REG_TIMER:   mmio_read_value = timer_reg;
            REG_SCRATCH: mmio_read_value = scratch_reg;
            default:     mmio_read_value = 32'h0000_0000;
        endcase
    end

    always_comb begin
        led_next        = led_reg;
        num_next        = num_reg;
        timer_next      = timer_reg + 32'd1;
        scratch_next    = scratch_reg;
        mmio_rdata_next = mmio_rdata_reg;
        sel_mmio_next   = sel_mmio_reg;

        if (mmio_wr) begin
            case (reg_id)
                REG_LED: begin
                    // LED is only 16 bits wide, so only the two low lanes apply.
                    if (data_sram_wen[0]) led_next[7:0]  = data_sram_wdata[7:0];
                    if (data_sram_wen[1]) led_next[15:8] = data_sram_wdata[15:8];
                end
                REG_NUM:     num_next     = byte_merge(num_reg, data_sram_wdata, data_sram_wen);
                // A write replaces this cycle's increment.
                REG_TIMER:   timer_next   = byte_merge(timer_reg, data_sram_wdata, data_sram_wen);
                REG_SCRATCH: scratch_next = byte_merge(scratch_reg, data_sram_wdata, data_sram_wen);
                default:     ;
            endcase
        end

        // The select flag and MMIO read value only move on reads, so the
        // rdata mux output holds across writes and idle cycles.
        if (rd_req) begin
            sel_mmio_next = mmio_sel;
            if (mmio_sel) begin
                mmio_rdata_next = mmio_read_value;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            led_reg        <= 16'h0000;
            num_reg        <= 32'h0000_0000;
            timer_reg      <= 32'h0000_0000;
            scratch_reg    <= 32'h0000_0000;
            mmio_rdata_reg <= 32'h0000_0000;
            sel_mmio_reg   <= 1'b0;
        end else begin
            led_reg        <= led_next;
            num_reg        <= num_next;
            timer_reg      <= timer_next;
            scratch_reg    <= scratch_next;
            mmio_rdata_reg <= mmio_rdata_next;
            sel_mmio_reg   <= sel_mmio_next;
        end
    end

    // ------------------------------------------------------------- outputs
    assign data_sram_rdata = sel_mmio_reg ? mmio_rdata_reg : ram_rdata;
    assign led             = led_reg;
    assign num             = num_reg;

endmodule
